// File: rtl/kernel_mem_host.sv
// rtl/kernel_mem_host.sv - host companion for a kernel with one single-port memory argument
// Loads a RAM from a stream, starts the kernel, serves its memory port and returns its result.
module kernel_mem_host #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [31:0]   res_data,
  output logic          err_oob,
  output logic          k_start,
  output logic [31:0]   k_n,
  input  logic          k_done,
  input  logic [31:0]   k_return_val,
  input  logic [31:0]   mem_address0,
  input  logic [DW-1:0] mem_d0,
  input  logic          mem_ce0,
  input  logic          mem_we0,
  output logic [DW-1:0] mem_q0
);

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_START  = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  localparam logic [31:0]   DEPTH_W  = 32'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [31:0]   k_n_q, k_n_d;
  logic [31:0]   res_data_q, res_data_d;
  logic [DW-1:0] mem_q0_q, mem_q0_d;
  logic          err_oob_q, err_oob_d;

  logic [DW-1:0] ram [DEPTH];
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;

  logic port_live;
  logic addr_ok;

  // Host-side handshakes come straight from the state register: no input-to-output paths.
  assign ld_ready  = (state_q == ST_LOAD);
  assign res_valid = (state_q == ST_RESULT);
  assign k_start   = (state_q == ST_START);
  assign k_n       = k_n_q;
  assign res_data  = res_data_q;
  assign mem_q0    = mem_q0_q;
  assign err_oob   = err_oob_q;

  assign port_live = (state_q == ST_START) || (state_q == ST_WAIT);
  assign addr_ok   = (mem_address0 < DEPTH_W);

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    k_n_d      = k_n_q;
    res_data_d = res_data_q;
    mem_q0_d   = mem_q0_q;
    err_oob_d  = err_oob_q;
    ram_we     = 1'b0;
    ram_waddr  = wptr_q;
    ram_wdata  = ld_data;

    case (state_q)
      ST_LOAD: begin
        if (ld_valid) begin
          ram_we = 1'b1;
          // A full buffer closes the burst regardless of ld_last.
          if (ld_last || (wptr_q == LAST_IDX)) begin
            k_n_d   = 32'(wptr_q) + 32'd1;
            wptr_d  = '0;
            state_d = ST_START;
          end else begin
            wptr_d = wptr_q + AW'(1);
          end
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (k_done) begin
          res_data_d = k_return_val;
          state_d    = ST_RESULT;
        end
      end
      default: begin
        if (res_ready) state_d = ST_LOAD;
      end
    endcase

    if (port_live && mem_ce0) begin
      if (!addr_ok) err_oob_d = 1'b1;
      if (mem_we0) begin
        if (addr_ok) begin
          ram_we    = 1'b1;
          ram_waddr = mem_address0[AW-1:0];
          ram_wdata = mem_d0;
        end
      end else begin
        mem_q0_d = addr_ok ? ram[mem_address0[AW-1:0]] : '0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_LOAD;
      wptr_q     <= '0;
      k_n_q      <= '0;
      res_data_q <= '0;
      mem_q0_q   <= '0;
      err_oob_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      k_n_q      <= k_n_d;
      res_data_q <= res_data_d;
      mem_q0_q   <= mem_q0_d;
      err_oob_q  <= err_oob_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge sys_clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

endmodule

// File: doc/kernel_mem_host.md
# kernel_mem_host

Host-side companion for a generated kernel with a single-port memory argument and a start/idle/done handshake. The block owns a DEPTH-word single-port RAM that answers the kernel's `address0/d0/ce0/we0/q0` memory port, and fills that RAM from a valid/ready load stream. It then drives the argument `n` and pulses `start`, waits for `done`, and returns the kernel's `return_val` on a valid/ready result port. It sits between the testbench or SoC host and one kernel instance.

## Interface
- DEPTH, 16, RAM words; power of two, ≥2
- AW, 4, RAM index width, log2(DEPTH)
- DW, 32, data width of RAM words, load data, and kernel data

- sys_clk  in  1  single clock, rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- ld_valid  in  1  load word present
- ld_ready  out  1  block accepts a load word
- ld_data  in  DW  load word
- ld_last  in  1  marks the final word of a load burst
- res_valid  out  1  result held
- res_ready  in  1  host consumes result
- res_data  out  32  captured kernel return value
- err_oob  out  1  sticky flag: kernel accessed an address ≥ DEPTH
- k_start  out  1  kernel start pulse
- k_n  out  32  kernel argument n, the number of words loaded
- k_done  in  1  kernel done
- k_return_val  in  32  kernel return value
- mem_address0  in  32  kernel memory address (word index)
- mem_d0  in  DW  kernel write data
- mem_ce0  in  1  kernel memory enable
- mem_we0  in  1  kernel write enable
- mem_q0  out  DW  read data to kernel

## Operation
- FSM states: LOAD, START, WAIT, RESULT. Reset state is LOAD.
- **LOAD**
  - ld_ready = 1.
  - A word is accepted when ld_valid & ld_ready; it is written to RAM[wptr] and wptr increments.
  - On accepting a word with ld_last=1, or on accepting the word at wptr == DEPTH-1 (full; ld_last is ignored): latch k_n = wptr+1 (zero-extended), clear wptr, go to START.
  - Kernel memory port is ignored: mem_q0 holds, no writes.
- **START**
  - k_start = 1 for exactly this one cycle, then go to WAIT.
  - k_done is ignored in this state.
- **WAIT**
  - The kernel port is live.
  - On the first cycle with k_done=1: capture res_data = k_return_val, go to RESULT.
- **RESULT**
  - res_valid = 1; res_data is stable.
  - On res_valid & res_ready: go to LOAD.
- **Kernel port** (active in START and WAIT only)
  - Write: mem_ce0 & mem_we0 & addr<DEPTH writes RAM[addr[AW-1:0]] = mem_d0 at the clock edge; mem_q0 is unchanged.
  - Read: mem_ce0 & ~mem_we0 & addr<DEPTH gives mem_q0 = RAM[addr] on the next cycle.
  - Out-of-range access (addr ≥ DEPTH, full 32-bit compare):
    - a write is discarded;
    - a read returns 0 next cycle;
    - err_oob is set and stays set until reset.
  - mem_ce0 = 0: mem_q0 holds its last value.
- **k_n** holds its value from START until the next latch.
- **RAM** contents are not reset. A reset mid-operation returns the FSM to LOAD with wptr = 0. The kernel must be reset alongside.

## Timing
- Reset values: ld_ready=1, res_valid=0, res_data=0, k_start=0, k_n=0, mem_q0=0, err_oob=0; wptr=0.
- ld_ready and res_valid are decoded from the state register, so there are no combinational input-to-output paths on the host ports.
- Final load accept at edge t → START during cycle t+1, k_start high in cycle t+1 only, WAIT from t+2.
- Kernel read latency is 1 cycle (BRAM-style q0).
- k_done sampled high at edge t in WAIT → res_valid=1 from cycle t+1.
- Result consumed at edge t → ld_ready=1 from cycle t+1. A new burst may start immediately.
- k_done held high across several cycles causes exactly one capture.
- Back-to-back kernel accesses on consecutive cycles are all served; no stalls.

## Test plan
- **Reset:** assert sys_rst_n=0 mid-WAIT → all outputs at their reset values, ld_ready=1 after release, k_start never pulses until a new load completes.
- **Load 5 words** {1,2,3,4,5} with ld_last on the 5th → k_n=5, one single-cycle k_start. Kernel model sums reads at 0..4 and returns 15 → res_data=15, res_valid held until res_ready.
- **Full buffer:** load 16 words with ld_last=0 throughout → transition after the 16th word, k_n=16, and ld_ready=0 in the following cycle.
- **Kernel write-then-read:** kernel writes 0xDEAD at addr 3, then reads addr 3 → mem_q0=0xDEAD one cycle after the read request. A read of addr 2 returns the loaded value.
- **Out-of-range:** kernel reads addr 16 and writes 0x1234 to addr 0x8000_0000 → mem_q0=0, RAM unchanged, err_oob=1 persisting through later runs until reset.
- **Handshake stress:** hold k_done high for 3 cycles and keep res_ready low for 4 cycles → single capture, res_data stable. Return to LOAD the cycle after res_ready; a 1-word burst then yields k_n=1.
